vx_gpr_rsp_collector: RTL and testbench

- Parametrised GPR read-response collector between the banked register file and the issue stage.
- Accepts one operand-read request, then gathers requested operands (rs1..rsN) arriving one per cycle in any order.
- Packs the completed operand set and queues it in a DEPTH-entry response FIFO with a valid/ready handshake to issue.
- Generalises the fixed 3-operand, 32-bit, combinational GPR response bundle to N operands, configurable width, tagged, buffered responses.

---
 rtl/vx_gpr_rsp_collector.sv | 142 ++++++++++++++
 tb/tb_vx_gpr_rsp_collector.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_gpr_rsp_collector.sv
// GPR read-response collector: gathers the requested operands of one request
// in any arrival order, then queues the packed, tagged set in a response FIFO.
module vx_gpr_rsp_collector #(
  parameter int unsigned NUM_THREADS  = 4,
  parameter int unsigned NUM_OPERANDS = 3,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned TAG_WIDTH    = 4,
  parameter int unsigned DEPTH        = 2,
  localparam int unsigned IDX_W  = (NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1,
  localparam int unsigned LANE_W = NUM_THREADS * DATA_WIDTH,
  localparam int unsigned PACK_W = NUM_OPERANDS * LANE_W
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [TAG_WIDTH-1:0]    req_tag,
  input  logic [NUM_OPERANDS-1:0] req_mask,
  input  logic                    opd_valid,
  input  logic [IDX_W-1:0]        opd_idx,
  input  logic [LANE_W-1:0]       opd_data,
  output logic                    opd_err,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [TAG_WIDTH-1:0]    rsp_tag,
  output logic [PACK_W-1:0]       rsp_data,
  output logic                    busy
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_PUSH} state_t;

  state_t                  r_state, w_state_nxt;
  logic [TAG_WIDTH-1:0]    r_tag;
  logic [NUM_OPERANDS-1:0] r_mask, r_coll, w_sel;
  logic [LANE_W-1:0]       r_opd [NUM_OPERANDS];
  logic                    r_err;
  logic                    w_hit, w_done, w_full, w_push, w_pop;
  logic [PACK_W-1:0]       w_pack;

  logic [TAG_WIDTH-1:0]    r_fifo_tag  [DEPTH];
  logic [PACK_W-1:0]       r_fifo_data [DEPTH];
  logic [PTR_W-1:0]        r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]        r_count;

  function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction

  // One-hot slot decode; an out-of-range index decodes to all-zero and so never hits.
  always_comb begin
    w_sel = '0;
    for (int unsigned o = 0; o < NUM_OPERANDS; o++) begin
      w_sel[o] = (32'(opd_idx) == o);
    end
    w_hit  = opd_valid && (r_state == S_COLLECT) && (|(w_sel & r_mask & ~r_coll));
    w_done = w_hit && ((r_coll | w_sel) == r_mask);
    w_full = 32'(r_count) >= DEPTH;
    w_push = (r_state == S_PUSH) && !w_full;
    w_pop  = (r_count != '0) && rsp_ready;
  end

  always_comb begin
    w_pack = '0;
    for (int unsigned o = 0; o < NUM_OPERANDS; o++) begin
      w_pack[o*LANE_W +: LANE_W] = r_opd[o];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:    if (req_valid) w_state_nxt = (req_mask == '0) ? S_PUSH : S_COLLECT;
      S_COLLECT: if (w_done) w_state_nxt = S_PUSH;
      S_PUSH:    if (!w_full) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tag  <= '0;
      r_mask <= '0;
      r_coll <= '0;
      r_err  <= 1'b0;
      for (int unsigned o = 0; o < NUM_OPERANDS; o++) r_opd[o] <= '0;
    end else begin
      r_err <= opd_valid && !w_hit;
      if ((r_state == S_IDLE) && req_valid) begin
        r_tag  <= req_tag;
        r_mask <= req_mask;
        r_coll <= '0;
        for (int unsigned o = 0; o < NUM_OPERANDS; o++) r_opd[o] <= '0;
      end else if (w_hit) begin
        r_coll <= r_coll | w_sel;
        for (int unsigned o = 0; o < NUM_OPERANDS; o++) begin
          if (w_sel[o]) r_opd[o] <= opd_data;
        end
      end
    end
  end

  // Fullness is judged on the registered count, so a pop never frees a slot for the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int unsigned d = 0; d < DEPTH; d++) begin
        r_fifo_tag[d]  <= '0;
        r_fifo_data[d] <= '0;
      end
    end else begin
      if (w_push) begin
        r_fifo_tag[r_wr_ptr]  <= r_tag;
        r_fifo_data[r_wr_ptr] <= w_pack;
        r_wr_ptr              <= f_ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= f_ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_count != '0);
  assign rsp_tag   = rsp_valid ? r_fifo_tag[r_rd_ptr]  : '0;
  assign rsp_data  = rsp_valid ? r_fifo_data[r_rd_ptr] : '0;
  assign opd_err   = r_err;
  assign busy      = (r_state != S_IDLE) || rsp_valid;

endmodule

// File: tb/tb_vx_gpr_rsp_collector.sv
// Bench for vx_gpr_rsp_collector: directed latency/error/backpressure/reset steps
// plus randomized requests scored against an in-order queue of expected responses.
module tb_vx_gpr_rsp_collector;

  localparam int NT = 4;
  localparam int NO = 3;
  localparam int DW = 32;
  localparam int TW = 4;
  localparam int DP = 2;
  localparam int IW = 2;
  localparam int LW = NT * DW;
  localparam int PW = NO * LW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req_valid, req_ready;
  logic [TW-1:0] req_tag;
  logic [NO-1:0] req_mask;
  logic          opd_valid;
  logic [IW-1:0] opd_idx;
  logic [LW-1:0] opd_data;
  logic          opd_err;
  logic          rsp_valid, rsp_ready;
  logic [TW-1:0] rsp_tag;
  logic [PW-1:0] rsp_data;
  logic          busy;

  vx_gpr_rsp_collector #(
    .NUM_THREADS (NT),
    .NUM_OPERANDS(NO),
    .DATA_WIDTH  (DW),
    .TAG_WIDTH   (TW),
    .DEPTH       (DP)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_tag  (req_tag),
    .req_mask (req_mask),
    .opd_valid(opd_valid),
    .opd_idx  (opd_idx),
    .opd_data (opd_data),
    .opd_err  (opd_err),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_tag  (rsp_tag),
    .rsp_data (rsp_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TW-1:0] tag;
    logic [PW-1:0] data;
  } rsp_t;

  rsp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   exp_bad = 1'b0;
  int   rdy_mode = 0;

  task automatic chk(input string name, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] rnd();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic beat(input int idx, input logic [LW-1:0] d, input bit bad);
    opd_valid = 1'b1;
    opd_idx   = idx[IW-1:0];
    opd_data  = d;
    exp_bad   = bad;
  endtask

  // One clock: score a pop if one happens at this edge, then check error pulse and hold stability.
  task automatic tick();
    bit            bad, hold;
    logic [TW-1:0] s_tag;
    logic [PW-1:0] s_data;
    rsp_t          e;
    bad    = exp_bad;
    hold   = rsp_valid && !rsp_ready;
    s_tag  = rsp_tag;
    s_data = rsp_data;
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) chk("rsp_extra", rsp_valid, 0);
      else begin
        e = exp_q.pop_front();
        chk("rsp_tag", rsp_tag, e.tag);
        chk("rsp_data", rsp_data, e.data);
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    opd_valid = 1'b0;
    exp_bad   = 1'b0;
    chk("opd_err", opd_err, bad);
    if (hold) begin
      chk("hold_valid", rsp_valid, 1);
      chk("hold_tag", rsp_tag, s_tag);
      chk("hold_data", rsp_data, s_data);
    end
    case (rdy_mode)
      0:       rsp_ready = 1'b0;
      1:       rsp_ready = 1'b1;
      default: rsp_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_req_ready"}, req_ready, 1);
    chk({pfx, "_rsp_valid"}, rsp_valid, 0);
    chk({pfx, "_rsp_tag"}, rsp_tag, 0);
    chk({pfx, "_rsp_data"}, rsp_data, 0);
    chk({pfx, "_opd_err"}, opd_err, 0);
    chk({pfx, "_busy"}, busy, 0);
  endtask

  task automatic run_req(input logic [TW-1:0] tag, input logic [NO-1:0] mask, input bit junk);
    int            n, j, tmp, idx;
    int            order[$];
    logic [NO-1:0] got;
    logic [LW-1:0] slot [NO];
    rsp_t          e;
    n = 0;
    while (!req_ready && n < 200) begin
      if (junk && $urandom_range(0, 2) == 0) beat(int'($urandom_range(0, 3)), rnd(), 1'b1);
      tick();
      n++;
    end
    chk("req_ready_wait", req_ready, 1);
    req_valid = 1'b1;
    req_tag   = tag;
    req_mask  = mask;
    if (junk && $urandom_range(0, 3) == 0) beat(int'($urandom_range(0, 3)), rnd(), 1'b1);
    e.tag  = tag;
    e.data = '0;
    for (int o = 0; o < NO; o++) begin
      slot[o] = mask[o] ? rnd() : '0;
      e.data[o*LW +: LW] = slot[o];
      if (mask[o]) order.push_back(o);
    end
    tick();
    if (mask == '0) exp_q.push_back(e);
    for (int i = order.size() - 1; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    got = '0;
    foreach (order[i]) begin
      if (junk && $urandom_range(0, 1) == 1) begin
        idx = 3;
        case ($urandom_range(0, 2))
          0: for (int b = 0; b < NO; b++) if (got[b]) idx = b;
          1: for (int b = 0; b < NO; b++) if (!mask[b]) idx = b;
          default: idx = 3;
        endcase
        beat(idx, rnd(), 1'b1);
        tick();
      end
      beat(order[i], slot[order[i]], 1'b0);
      tick();
      got[order[i]] = 1'b1;
    end
    if (mask != '0) exp_q.push_back(e);
  endtask

  task automatic drain();
    int n;
    rdy_mode  = 1;
    rsp_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || rsp_valid || !req_ready) && n < 200) begin
      tick();
      n++;
    end
    chk("drain_pending", 32'(exp_q.size()), 0);
    chk("drain_rsp_valid", rsp_valid, 0);
    chk("drain_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    logic [LW-1:0] aa, bb, x0, z2;
    rsp_t          e;
    reset_n = 1'b0; req_valid = 1'b0; req_tag = '0; req_mask = '0;
    opd_valid = 1'b0; opd_idx = '0; opd_data = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst");
    reset_n = 1'b1;
    tick();
    chk_reset("post_rst");

    // Mask 101, tag 5, beats idx2 then idx0: exact response latency.
    aa = {32'hAA00_0003, 32'hAA00_0002, 32'hAA00_0001, 32'hAA00_0000};
    bb = {32'hBB00_0003, 32'hBB00_0002, 32'hBB00_0001, 32'hBB00_0000};
    req_valid = 1'b1; req_tag = 4'd5; req_mask = 3'b101;
    tick();
    chk("t1_collect_req_ready", req_ready, 0);
    chk("t1_collect_busy", busy, 1);
    beat(2, bb, 1'b0); tick();
    beat(0, aa, 1'b0); tick();
    chk("t1_push_rsp_valid", rsp_valid, 0);
    chk("t1_push_req_ready", req_ready, 0);
    e.tag = 4'd5; e.data = {bb, {LW{1'b0}}, aa};
    exp_q.push_back(e);
    tick();
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_tag", rsp_tag, 4'd5);
    chk("t1_rsp_data", rsp_data, e.data);
    chk("t1_req_ready", req_ready, 1);
    rsp_ready = 1'b1; tick();
    chk("t1_popped", rsp_valid, 0);
    chk("t1_idle_busy", busy, 0);

    // Empty mask: response two cycles after acceptance, all-zero data.
    req_valid = 1'b1; req_tag = 4'd9; req_mask = 3'b000;
    tick();
    chk("t2_rsp_valid_early", rsp_valid, 0);
    e.tag = 4'd9; e.data = '0;
    exp_q.push_back(e);
    tick();
    chk("t2_rsp_valid", rsp_valid, 1);
    chk("t2_rsp_tag", rsp_tag, 4'd9);
    chk("t2_rsp_data", rsp_data, 0);
    rsp_ready = 1'b1; tick();

    // Dropped beats: duplicate, unrequested, out-of-range, during PUSH and IDLE.
    x0 = rnd(); z2 = rnd();
    req_valid = 1'b1; req_tag = 4'd3; req_mask = 3'b101;
    tick();
    beat(0, x0, 1'b0);    tick();
    beat(0, rnd(), 1'b1); tick();
    beat(1, rnd(), 1'b1); tick();
    beat(3, rnd(), 1'b1); tick();
    beat(2, z2, 1'b0);    tick();
    e.tag = 4'd3; e.data = {z2, {LW{1'b0}}, x0};
    exp_q.push_back(e);
    chk("t3_in_push", req_ready, 0);
    beat(1, rnd(), 1'b1); tick();
    chk("t3_idle", req_ready, 1);
    beat(0, rnd(), 1'b1); tick();
    rsp_ready = 1'b1; tick();
    chk("t3_popped", rsp_valid, 0);

    // Backpressure: two entries fill the FIFO, third waits in PUSH with no bypass.
    rdy_mode = 0; rsp_ready = 1'b0;
    run_req(4'd1, 3'b111, 1'b0);
    run_req(4'd2, 3'b111, 1'b0);
    run_req(4'd3, 3'b111, 1'b0);
    repeat (3) tick();
    chk("t4_full_req_ready", req_ready, 0);
    chk("t4_full_busy", busy, 1);
    chk("t4_full_rsp_valid", rsp_valid, 1);
    chk("t4_full_head", rsp_tag, 4'd1);
    rsp_ready = 1'b1; tick();
    chk("t4_no_bypass", req_ready, 0);
    chk("t4_head2", rsp_tag, 4'd2);
    tick();
    chk("t4_pushed", req_ready, 1);
    drain();

    // Back-to-back with consumer always ready: pointers wrap several times.
    rdy_mode = 1; rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) run_req(TW'(i + 4), NO'($urandom_range(0, 7)), 1'b0);
    drain();

    // Randomized requests, random backpressure, injected bad beats.
    rdy_mode = 2;
    for (int i = 0; i < 40; i++) run_req(TW'($urandom()), NO'($urandom_range(0, 7)), 1'b1);
    drain();

    // Asynchronous reset mid-collection with one queued entry.
    rdy_mode = 0; rsp_ready = 1'b0;
    run_req(4'd7, 3'b010, 1'b0);
    tick(); tick();
    chk("t7_queued", rsp_valid, 1);
    req_valid = 1'b1; req_tag = 4'd8; req_mask = 3'b011;
    tick();
    beat(0, rnd(), 1'b0); tick();
    chk("t7_collecting", req_ready, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset("t7_async");
    exp_q.delete();
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    tick();
    chk_reset("t7_release");
    rdy_mode = 1; rsp_ready = 1'b1;
    run_req(4'hA, 3'b110, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
